display_dec: RTL and testbench



---
 rtl/display_pkg.sv | 40 ++++
 rtl/seg7_lut.sv | 33 +++
 rtl/display_dec.sv | 41 ++++
 tb/tb_display_dec.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared glyph codes and segment bit positions for the front-panel display decoder.
// DISPLAY_DEC_ACTIVE_LOW_EN selects common-anode polarity for the off value.
package display_pkg;

  localparam int WORD_W = 8;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Glyphs are stored active-high as gfedcba; polarity is applied at the output register
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A_U = 7'h77;
  localparam logic [6:0] SEG_B_L = 7'h7C;
  localparam logic [6:0] SEG_C_U = 7'h39;
  localparam logic [6:0] SEG_D_L = 7'h5E;
  localparam logic [6:0] SEG_E_U = 7'h79;
  localparam logic [6:0] SEG_F_U = 7'h71;

`ifdef DISPLAY_DEC_ACTIVE_LOW_EN
  localparam logic [WORD_W-1:0] SEG_OFF = 8'hFF;
`else
  localparam logic [WORD_W-1:0] SEG_OFF = 8'h00;
`endif

endpackage

// File: rtl/seg7_lut.sv
// Combinational hex nibble to active-high 7-segment glyph lookup (gfedcba).
module seg7_lut
  import display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] glyph
);

  // All sixteen codes are listed; the leading default only keeps unknown inputs from propagating X
  always_comb begin
    glyph = 7'h00;
    case (digit)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'hA: glyph = SEG_A_U;
      4'hB: glyph = SEG_B_L;
      4'hC: glyph = SEG_C_U;
      4'hD: glyph = SEG_D_L;
      4'hE: glyph = SEG_E_U;
      4'hF: glyph = SEG_F_U;
      default: glyph = 7'h00;
    endcase
  end

endmodule

// File: rtl/display_dec.sv
// Registered hex to 7-segment decoder driving the oven front-panel digit pins.
// Define DISPLAY_DEC_ACTIVE_LOW_EN for common-anode panels (inverted word, off = 8'hFF).
module display_dec
  import display_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        digit,
  output logic [WORD_W-1:0] word
);

  logic [6:0]        glyph;
  logic [WORD_W-1:0] word_active;
  logic [WORD_W-1:0] word_next;

  seg7_lut u_lut (
    .digit (digit),
    .glyph (glyph)
  );

  // The decimal point is reserved, so it is always driven to its inactive level
  always_comb begin
    word_active                = '0;
    word_active[SEG_G:SEG_A]   = glyph;
    word_active[SEG_DP]        = 1'b0;
`ifdef DISPLAY_DEC_ACTIVE_LOW_EN
    word_next = ~word_active;
`else
    word_next = word_active;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= SEG_OFF;
    end else begin
      word <= word_next;
    end
  end

endmodule

// File: tb/tb_display_dec.sv
// Self-checking bench for display_dec: directed vector table, reset corner cases and random traffic.
// Expected values follow DISPLAY_DEC_ACTIVE_LOW_EN when the bench is built with it.
module tb_display_dec;

  logic       clk;
  logic       rst;
  logic [3:0] digit;
  logic [7:0] word;

  int compared;
  int mismatched;

  typedef struct {
    logic [3:0] digit;
    logic [7:0] expected;
  } vec_t;

  vec_t vecs[16];

  // Reference glyphs described by which named segments are lit
  string lit[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                     "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  display_dec dut (
    .clk   (clk),
    .rst   (rst),
    .digit (digit),
    .word  (word)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] panel(input logic [7:0] w);
`ifdef DISPLAY_DEC_ACTIVE_LOW_EN
    return ~w;
`else
    return w;
`endif
  endfunction

  function automatic logic [7:0] model(input int d);
    logic [7:0] w;
    string      s;
    w = 8'h00;
    s = lit[d];
    for (int i = 0; i < s.len(); i++) begin
      w[int'(s.getc(i)) - 97] = 1'b1;
    end
    return panel(w);
  endfunction

  // Drive a digit at the falling edge and return at the falling edge after it was captured
  task automatic applyStimulus(input logic [3:0] d);
    digit = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] exp);
    compared++;
    if (word !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: word=%h expected=%h", name, word, exp);
    end
  endtask

  initial begin
    logic [7:0] off;
    logic [3:0] d;
    bit         hold;

    compared   = 0;
    mismatched = 0;
    off        = panel(8'h00);

    vecs[0]  = '{4'h0, 8'h3F};  vecs[1]  = '{4'h1, 8'h06};
    vecs[2]  = '{4'h2, 8'h5B};  vecs[3]  = '{4'h3, 8'h4F};
    vecs[4]  = '{4'h4, 8'h66};  vecs[5]  = '{4'h5, 8'h6D};
    vecs[6]  = '{4'h6, 8'h7D};  vecs[7]  = '{4'h7, 8'h07};
    vecs[8]  = '{4'h8, 8'h7F};  vecs[9]  = '{4'h9, 8'h6F};
    vecs[10] = '{4'hA, 8'h77};  vecs[11] = '{4'hB, 8'h7C};
    vecs[12] = '{4'hC, 8'h39};  vecs[13] = '{4'hD, 8'h5E};
    vecs[14] = '{4'hE, 8'h79};  vecs[15] = '{4'hF, 8'h71};

    rst   = 1'b0;
    digit = 4'h5;
    #1 rst = 1'b1;
    #1 checkOutput("reset_immediate", off);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 checkOutput("reset_held", off);
    end

    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("release_before_edge", off);
    digit = 4'h0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("first_after_release", panel(8'h3F));

    digit = 4'h3;
    #1 checkOutput("hold_until_edge", panel(8'h3F));
    @(posedge clk);
    @(negedge clk);
    checkOutput("digit3", panel(8'h4F));

    applyStimulus(4'h9);
    checkOutput("digit9", panel(8'h6F));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("digit9_stable", panel(8'h6F));
    end

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].digit);
      checkOutput($sformatf("sweep_%h", vecs[i].digit), panel(vecs[i].expected));
      compared++;
      if (word[7] !== off[7]) begin
        mismatched++;
        $display("[TB] FAIL dp_%h: dp=%b expected=%b", vecs[i].digit, word[7], off[7]);
      end
    end

    applyStimulus(4'h8);
    checkOutput("digit8", panel(8'h7F));
    #1 rst = 1'b1;
    #1 checkOutput("pulse_reset_async", off);
    #1 rst = 1'b0;
    #1 checkOutput("pulse_reset_kept", off);
    @(posedge clk);
    @(negedge clk);
    checkOutput("after_pulse", panel(8'h7F));

    // Random traffic, occasionally holding reset across an edge
    for (int n = 0; n < 300; n++) begin
      d    = 4'($urandom_range(0, 15));
      hold = ($urandom_range(0, 7) == 0);
      rst  = hold;
      applyStimulus(d);
      checkOutput(hold ? "rand_reset" : "rand_digit", hold ? off : model(int'(d)));
      rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
